div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: operand and result width in bits.
REQ-002 Parameter N_REQ, default 4: number of requesters (2..16).
REQ-003 Port clk, input, 1: single clock, rising-edge active.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port req, input, N_REQ: per-requester division request, level.
REQ-006 Port dividend_in, input, N_REQ*DATA_W: packed dividends; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-007 Port divisor_in, input, N_REQ*DATA_W: packed divisors, same packing.
REQ-008 Port grant, output, N_REQ: one-hot, one-cycle pulse; request consumed, operands captured.
REQ-009 Port resp_valid, output, 1: one-cycle pulse; result fields valid.
REQ-010 Port resp_id, output, $clog2(N_REQ): index of the requester owning the result.
REQ-011 Port quotient, output, DATA_W: result quotient, held until the next resp_valid.
REQ-012 Port remainder, output, DATA_W: result remainder, held until the next resp_valid.
REQ-013 Port div_zero, output, 1: with resp_valid, flags a divisor of 0.
REQ-014 Port busy, output, 1: high while a divider operation is in flight.
REQ-015 Port div_en, output, 1: divider enable; held high for a whole operation.
REQ-016 Port div_dividend / div_divisor, output, DATA_W each: registered operands to the divider.
REQ-017 Port div_done, input, 1: divider completion flag; valid only while div_en is high.
REQ-018 Port div_quotient / div_remainder, input, DATA_W each: divider results.

Function
REQ-019 The FSM SHALL have two states: IDLE and RUN.
REQ-020 Arbitration SHALL be round-robin: priority starts at last_served+1 mod N_REQ; last_served updates on every grant.
REQ-021 In IDLE with any req bit high, the next edge SHALL:
- register a one-hot grant for the winner;
- latch the winner's operands into div_dividend and div_divisor;
- set resp_id to the winner.
REQ-022 If the latched divisor is nonzero, the same edge SHALL set div_en=1 and busy=1, and enter RUN.
REQ-023 If the latched divisor is 0, the same edge SHALL:
- keep div_en=0 and stay in IDLE;
- set resp_valid=1 and div_zero=1;
- set quotient to all ones and remainder to the dividend.
REQ-024 In RUN, the edge that samples div_done=1 SHALL:
- capture div_quotient and div_remainder;
- set resp_valid=1 and div_zero=0;
- clear div_en and busy;
- return to IDLE.
REQ-025 div_en SHALL be low for at least one full cycle between consecutive operations, so the divider re-arms; IDLE provides this cycle.
REQ-026 Back-to-back issue SHALL be allowed: the cycle after completion, IDLE may grant again (one cycle of div_en=0).
REQ-027 grant, resp_valid and div_zero SHALL each be high for exactly one cycle per event.
REQ-028 req bits SHALL be ignored while in RUN; a req still high after its grant SHALL count as a new request.
REQ-029 Operands SHALL be sampled only at the grant edge; later changes on dividend_in/divisor_in SHALL NOT affect the operation in flight.
REQ-030 Latency SHALL be: grant 1 cycle after req is seen in IDLE; resp_valid 1 cycle after div_done is sampled high. Total = divider latency + 2 cycles.
REQ-031 div_done sampled while in IDLE SHALL be ignored.
REQ-032 A single requester holding req continuously SHALL be served every (divider latency + 2) cycles; other requesters SHALL NOT starve (at most N_REQ-1 grants between two grants to any waiting requester).

Reset
REQ-033 On rst_n low, asynchronously and with no clock edge, the block SHALL:
- enter IDLE;
- set last_served=N_REQ-1, so requester 0 has first priority;
- clear grant, resp_valid, div_zero, busy, div_en, div_dividend, div_divisor, resp_id, quotient and remainder to 0.
REQ-034 Reset asserted during RUN SHALL abort the operation with no resp_valid; after reset, the abandoned request SHALL be re-served only if its req is still high.

Verification
REQ-035 Single request: req=0001, dividend 1<<46, divisor 1<<22 (DATA_W=56) -> grant=0001; div_en held high until done; resp_valid with resp_id=0, quotient=16777216, remainder=0.
REQ-036 All four req high, continuously -> grants in order 0,1,2,3,0; between operations div_en low exactly one cycle; each result matches the reference division.
REQ-037 Divide by zero: req=0100, dividend 1234, divisor 0 -> grant and resp_valid in the same cycle; resp_id=2, div_zero=1, quotient=all ones, remainder=1234; div_en never rises.
REQ-038 Operand change after grant: dividend 100, divisor 7, then inputs changed to 9/3 during RUN -> quotient=14, remainder=2.
REQ-039 Reset in RUN: rst_n pulsed low mid-operation -> div_en and busy drop with no clock edge; no resp_valid; after release with req=0010 held -> grant=0010 first.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end that shares one multi-cycle divider
// among N_REQ requesters.
//
// A grant captures the winner's operands into div_dividend/div_divisor and
// starts the divider by raising div_en, which stays high until the divider
// reports div_done. A zero divisor is answered at the grant edge without
// starting the divider: quotient = all ones, remainder = dividend.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   req[N_REQ]                   level requests, one per requester
//   dividend_in, divisor_in      packed operands, requester k at [k*DATA_W +: DATA_W]
//   grant[N_REQ]                 one-hot, one-cycle pulse when a request is taken
//   resp_valid                   one-cycle pulse, result fields valid
//   resp_id                      requester owning the current result
//   quotient, remainder          result, held until the next resp_valid
//   div_zero                     with resp_valid, the divisor was 0
//   busy                         a divider operation is in flight
//   div_en                       divider enable, high for the whole operation
//   div_dividend, div_divisor    registered divider operands
//   div_done                     divider completion, honoured only while div_en is high
//   div_quotient, div_remainder  divider results
module div_arbiter #(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_W-1:0]    dividend_in,
  input  logic [N_REQ*DATA_W-1:0]    divisor_in,
  output logic [N_REQ-1:0]           grant,
  output logic                       resp_valid,
  output logic [$clog2(N_REQ)-1:0]   resp_id,
  output logic [DATA_W-1:0]          quotient,
  output logic [DATA_W-1:0]          remainder,
  output logic                       div_zero,
  output logic                       busy,
  output logic                       div_en,
  output logic [DATA_W-1:0]          div_dividend,
  output logic [DATA_W-1:0]          div_divisor,
  input  logic                       div_done,
  input  logic [DATA_W-1:0]          div_quotient,
  input  logic [DATA_W-1:0]          div_remainder
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic                resp_valid_q, resp_valid_d;
  logic                div_zero_q, div_zero_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic [DATA_W-1:0]   quotient_q, quotient_d;
  logic [DATA_W-1:0]   remainder_q, remainder_d;
  logic [DATA_W-1:0]   div_dividend_q, div_dividend_d;
  logic [DATA_W-1:0]   div_divisor_q, div_divisor_d;

  // Round-robin pick: scan from last_q+1 upward (wrapping) and keep the
  // first requester found.
  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic [ID_W-1:0]     cand_idx;
  logic [DATA_W-1:0]   win_dividend;
  logic [DATA_W-1:0]   win_divisor;

  always_comb begin
    // NOTE: every signal driven here gets a default before any branch, so
    // no path can leave it unassigned and infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_idx = ID_W'((int'(last_q) + i) % N_REQ);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign win_dividend = dividend_in[win_idx*DATA_W +: DATA_W];
  assign win_divisor  = divisor_in[win_idx*DATA_W +: DATA_W];

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    grant_d        = '0;
    resp_valid_d   = 1'b0;
    div_zero_d     = 1'b0;
    resp_id_d      = resp_id_q;
    quotient_d     = quotient_q;
    remainder_d    = remainder_q;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;

    case (state_q)
      IDLE: begin
        // div_done is deliberately ignored here; IDLE is also the one-cycle
        // gap with div_en low that lets the divider re-arm.
        if (win_found) begin
          grant_d        = N_REQ'(1) << win_idx;
          last_d         = win_idx;
          resp_id_d      = win_idx;
          div_dividend_d = win_dividend;
          div_divisor_d  = win_divisor;
          if (win_divisor != '0) begin
            state_d = RUN;
          end else begin
            // Answer immediately; the divider is never started.
            resp_valid_d = 1'b1;
            div_zero_d   = 1'b1;
            quotient_d   = '1;
            remainder_d  = win_dividend;
          end
        end
      end
      RUN: begin
        // req is not looked at while the divider is busy.
        if (div_done) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          quotient_d   = div_quotient;
          remainder_d  = div_remainder;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_q         <= ID_W'(N_REQ - 1);
      grant_q        <= '0;
      resp_valid_q   <= 1'b0;
      div_zero_q     <= 1'b0;
      resp_id_q      <= '0;
      quotient_q     <= '0;
      remainder_q    <= '0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values of
      // the previous cycle, independent of statement order.
      state_q        <= state_d;
      last_q         <= last_d;
      grant_q        <= grant_d;
      resp_valid_q   <= resp_valid_d;
      div_zero_q     <= div_zero_d;
      resp_id_q      <= resp_id_d;
      quotient_q     <= quotient_d;
      remainder_q    <= remainder_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
    end
  end

  // div_en and busy both mean "in RUN"; decoding them from the state flop
  // makes them drop the moment reset is asserted, with no clock edge.
  assign div_en       = (state_q == RUN);
  assign busy         = div_en;
  assign grant        = grant_q;
  assign resp_valid   = resp_valid_q;
  assign div_zero     = div_zero_q;
  assign resp_id      = resp_id_q;
  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign div_dividend = div_dividend_q;
  assign div_divisor  = div_divisor_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed bench for div_arbiter (DATA_W=56, N_REQ=4) with a
// behavioural fixed-latency divider. Expected grants and responses are queued
// when stimulus is driven and compared by a monitor when the DUT produces them.
module tb_div_arbiter;

  localparam int DW  = 56;
  localparam int NR  = 4;
  localparam int LAT = 6;

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
  } resp_t;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  dividend_in;
  logic [NR*DW-1:0]  divisor_in;
  logic [NR-1:0]     grant;
  logic              resp_valid;
  logic [1:0]        resp_id;
  logic [DW-1:0]     quotient;
  logic [DW-1:0]     remainder;
  logic              div_zero;
  logic              busy;
  logic              div_en;
  logic [DW-1:0]     div_dividend;
  logic [DW-1:0]     div_divisor;
  logic              div_done;
  logic [DW-1:0]     div_quotient;
  logic [DW-1:0]     div_remainder;

  int checks = 0;
  int errors = 0;

  logic [NR-1:0] exp_grant[$];
  resp_t         exp_resp[$];
  int            gaps[$];
  int            low_cnt = 0;
  logic          prev_en = 1'b0;
  logic          en_rose = 1'b0;

  div_arbiter #(.DATA_W(DW), .N_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .dividend_in(dividend_in), .divisor_in(divisor_in),
    .grant(grant), .resp_valid(resp_valid), .resp_id(resp_id),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero),
    .busy(busy), .div_en(div_en),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: done rises LAT cycles after div_en rises, stays high while
  // div_en is high, and clears once div_en is low.
  int dcnt = 0;
  always @(posedge clk) begin
    if (!div_en) begin
      dcnt     <= 0;
      div_done <= 1'b0;
    end else if (!div_done) begin
      if (dcnt == LAT - 1) begin
        div_done      <= 1'b1;
        div_quotient  <= div_dividend / div_divisor;
        div_remainder <= div_dividend % div_divisor;
      end else begin
        dcnt <= dcnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard compare plus div_en gap bookkeeping.
  always @(negedge clk) begin
    if (rst_n) begin
      if (grant != '0) begin
        if (exp_grant.size() == 0) check("unexpected_grant", 64'(grant), 64'd0);
        else check("grant", 64'(grant), 64'(exp_grant.pop_front()));
      end
      if (resp_valid) begin
        if (exp_resp.size() == 0) check("unexpected_resp", 64'(resp_valid), 64'd0);
        else begin
          resp_t e;
          e = exp_resp.pop_front();
          check("resp_id", 64'(resp_id), 64'(e.id));
          check("quotient", 64'(quotient), 64'(e.q));
          check("remainder", 64'(remainder), 64'(e.r));
          check("div_zero", 64'(div_zero), 64'(e.dz));
        end
        check("busy_at_resp", 64'(busy), 64'(div_en));
      end
      if (div_en && !prev_en) begin
        en_rose = 1'b1;
        gaps.push_back(low_cnt);
      end
      if (prev_en && !div_en) check("en_drop_only_with_resp", 64'(resp_valid), 64'd1);
      if (!div_en) low_cnt++;
      else low_cnt = 0;
      prev_en = div_en;
    end else begin
      prev_en = 1'b0;
      low_cnt = 0;
    end
  end

  task automatic wait_grant(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (grant != '0) return;
    end
    check("grant_timeout", 64'(grant != '0), 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_resp.size() == 0 && exp_grant.size() == 0) break;
      @(negedge clk);
    end
    check("drain_resp", 64'(exp_resp.size()), 64'd0);
    check("drain_grant", 64'(exp_grant.size()), 64'd0);
  endtask

  task automatic set_ops(input int k, input logic [DW-1:0] dvd, input logic [DW-1:0] dvs);
    dividend_in[k*DW +: DW] = dvd;
    divisor_in[k*DW +: DW]  = dvs;
  endtask

  function automatic resp_t mk(input int id, input logic [DW-1:0] q,
                               input logic [DW-1:0] r, input logic dz);
    resp_t t;
    t.id = 2'(id); t.q = q; t.r = r; t.dz = dz;
    return t;
  endfunction

  initial begin
    int n;
    logic [DW-1:0] dvd[NR];
    logic [DW-1:0] dvs[NR];
    logic [DW-1:0] ones;

    ones        = '1;
    rst_n       = 1'b0;
    req         = '0;
    dividend_in = '0;
    divisor_in  = '0;

    // Reset state, before any clock edge.
    #3;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_div_en", 64'(div_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_div_dividend", 64'(div_dividend), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All four requesting continuously: 0,1,2,3,0 with one idle cycle between ops.
    for (int k = 0; k < NR; k++) begin
      dvd[k] = DW'({$urandom(), $urandom()});
      dvs[k] = DW'($urandom_range(1, 1 << 20));
      set_ops(k, dvd[k], dvs[k]);
    end
    for (int j = 0; j < 5; j++) begin
      int k;
      k = j % NR;
      exp_grant.push_back(NR'(1) << k);
      exp_resp.push_back(mk(k, dvd[k] / dvs[k], dvd[k] % dvs[k], 1'b0));
    end
    gaps.delete();
    req = 4'b1111;
    for (int j = 0; j < 5; j++) wait_grant(n);
    req = '0;
    wait_drain();
    check("rr_gap_count", 64'(gaps.size()), 64'd5);
    for (int j = 1; j < gaps.size(); j++) check("rr_gap_len", 64'(gaps[j]), 64'd1);

    // Single request, large operands; grant and response latency.
    set_ops(0, DW'(1) << 46, DW'(1) << 22);
    exp_grant.push_back(4'b0001);
    exp_resp.push_back(mk(0, DW'(16777216), '0, 1'b0));
    req = 4'b0001;
    wait_grant(n);
    req = '0;
    check("grant_latency", 64'(n), 64'd1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
    end
    check("resp_latency", 64'(n), 64'(LAT + 1));
    wait_drain();

    // Divide by zero: answered at the grant edge, divider untouched.
    set_ops(2, DW'(1234), '0);
    exp_grant.push_back(4'b0100);
    exp_resp.push_back(mk(2, ones, DW'(1234), 1'b1));
    en_rose = 1'b0;
    req = 4'b0100;
    wait_grant(n);
    req = '0;
    check("dz_resp_with_grant", 64'(resp_valid), 64'd1);
    check("dz_div_en", 64'(div_en), 64'd0);
    repeat (5) @(negedge clk);
    check("dz_en_never_rose", 64'(en_rose), 64'd0);
    check("dz_pulse_one_cycle", 64'(div_zero), 64'd0);
    wait_drain();

    // Operands changed after the grant must not affect the result.
    set_ops(0, DW'(100), DW'(7));
    exp_grant.push_back(4'b0001);
    exp_resp.push_back(mk(0, DW'(14), DW'(2), 1'b0));
    req = 4'b0001;
    wait_grant(n);
    req = '0;
    set_ops(0, DW'(9), DW'(3));
    wait_drain();

    // Reset mid-operation: aborts with no response; held request re-served.
    set_ops(1, DW'(5000), DW'(3));
    exp_grant.push_back(4'b0010);
    req = 4'b0010;
    wait_grant(n);
    repeat (2) @(negedge clk);
    check("pre_rst_div_en", 64'(div_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_div_en", 64'(div_en), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_resp_id", 64'(resp_id), 64'd0);
    repeat (2) @(negedge clk);
    check("rst_no_resp", 64'(resp_valid), 64'd0);
    #2 rst_n = 1'b1;
    exp_grant.push_back(4'b0010);
    exp_resp.push_back(mk(1, DW'(1666), DW'(2), 1'b0));
    wait_grant(n);
    req = '0;
    check("post_rst_grant", 64'(grant), 64'b0010);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
